ysyx_24100027_imm_pipe: RTL
===========================

# ysyx_24100027_imm_pipe

Pipelined, parametrised immediate-generation stage that sits between instruction decode and execute in the NPC core. It accepts an instruction word, an immediate-format selector and the instruction PC over a valid/ready handshake. It produces the sign- or zero-extended XLEN-bit immediate one cycle later. Beyond the I/U/S/B/J formats it covers the CSR zimm and shift-amount formats and flags illegal selectors. A two-entry skid buffer lets downstream stall without a combinational ready path back to decode.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents a transaction
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready
- in_inst  input  32  instruction word (bits [6:0] ignored)
- in_extop  input  3  immediate format selector
- in_pc  input  XLEN  PC of in_inst, carried through
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready
- out_imm  output  XLEN  extended immediate
- out_pc  output  XLEN  PC carried with the result
- out_illegal  output  1  extop was 3'b111
- out_target  output  XLEN  pc + imm (only with YSYX_24100027_IMM_TARGET_EN)

## Operation
- extop encoding, with sign extension to XLEN from inst[31] unless stated:
  - 000 I: inst[31:20]
  - 001 U: {inst[31:12], 12'h0}
  - 010 S: {inst[31:25], inst[11:7]}
  - 011 B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - 100 J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - 101 Z: inst[19:15], zero-extended
  - 110 SH: zero-extended shift amount; XLEN=32 uses inst[24:20], XLEN=64 uses inst[25:20]
  - 111: imm = 0, illegal = 1
- For every format other than 111, illegal = 0.
- Storage: one output register (main) plus one skid register; each holds {imm, pc, illegal[, target]} and a valid bit.
- Storage states, encoded as (main_v, skid_v):
  - EMPTY (0,0)
  - ONE (1,0)
  - FULL (1,1)
- in_ready = !skid_v. This is a registered-state function with no dependence on out_ready.
- Each cycle:
  - On an output transfer, the skid entry, if valid, moves into main.
  - On an input transfer, the new result fills main if main is free after that move; otherwise it fills skid.
  - A simultaneous input and output transfer in ONE stays in ONE with the new data in main.
- Transitions:
  - EMPTY→ONE on input.
  - ONE→FULL on input without output.
  - ONE→EMPTY on output without input.
  - FULL→ONE on output (no input is possible in FULL).
- Ordering: strict FIFO; no transaction is dropped or duplicated.
- out_* reflect the main register only.

## Timing
- Latency: an input accepted at edge N is visible on out_* after edge N; out_valid is high in cycle N+1.
- Throughput: 1 per cycle while out_ready is held high.
- out_valid and out_imm/out_pc/out_illegal are driven straight from flops; no combinational input→output path.
- rst high at an edge:
  - main_v and skid_v are cleared.
  - All data registers are set to 0.
  - out_valid = 0, out_imm = 0, out_pc = 0, out_illegal = 0, out_target = 0.
  - in_ready = 1 from the following cycle.
- Reset mid-operation discards any buffered transactions; no output transfer completes on the reset edge.
- While rst is high, in_ready = 0.
- out_imm and out_pc must be held stable while out_valid && !out_ready.

## Configuration
- YSYX_24100027_IMM_TARGET_EN defined:
  - The stage computes pc + imm (XLEN-bit, wrap-around, carry discarded) and registers it alongside the immediate, for branch/jump target use.
  - out_target follows the same valid, stall and reset rules as out_imm.
- Undefined: the out_target port and its adder and registers are absent.

## Test plan
- XLEN=32, in_inst=0xFFF00093, extop=000, in_pc=0x80000000 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0; with the target macro, out_target=0x7FFFFFFF.
- in_inst=0x12345037, extop=001 → out_imm=0x12345000. With XLEN=64 and in_inst=0x800000B7 → out_imm=0xFFFFFFFF80000000.
- B/J formats:
  - in_inst=0xFE000EE3, extop=011 → out_imm=0xFFFFFFFC.
  - in_inst=0x008000EF, extop=100, in_pc=0x100 → out_imm=0x8, out_target=0x108.
- Z, SH and illegal:
  - extop=101 with inst[19:15]=5'h1F → out_imm=0x1F.
  - extop=110 with XLEN=32 and inst=0x41F05013 → out_imm=0x1F.
  - extop=111 → out_imm=0, out_illegal=1.
- Backpressure:
  - Stream 4 back-to-back inputs with out_ready=0 → in_ready drops after the 2nd accept, and outputs hold the 1st result.
  - Raise out_ready → all 4 results appear in order with no loss or duplication, one per cycle once flowing.
- Reset mid-operation:
  - Assert rst for 1 cycle in state FULL → out_valid=0 and out_imm=0 the next cycle, and in_ready=1 after release.
  - A new input is then accepted and emerges with 1-cycle latency, with no stale data.

Source files
------------

// File: rtl/ysyx_24100027_imm_pipe.sv
// ysyx_24100027_imm_pipe: registered immediate generator with a two-entry skid buffer
// Define YSYX_24100027_IMM_TARGET_EN to also register pc + imm on out_target.
module ysyx_24100027_imm_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_extop,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
`ifdef YSYX_24100027_IMM_TARGET_EN
  output logic [XLEN-1:0] out_target,
`endif
  output logic            out_illegal
);
`ifdef YSYX_24100027_IMM_TARGET_EN
  localparam int EW = 3 * XLEN + 1;
`else
  localparam int EW = 2 * XLEN + 1;
`endif
  logic [31:0] i32;
  logic [5:0] zimm;
  logic [XLEN-1:0] sx, imm;
  logic [EW-1:0] new_e, main_q, skid_q;
  logic main_v, skid_v, in_fire, out_fire, main_free, zext, unused;
  always_comb begin
    i32 = in_extop == 3'd0 ? {{20{in_inst[31]}}, in_inst[31:20]} :
          in_extop == 3'd1 ? {in_inst[31:12], 12'h0} :
          in_extop == 3'd2 ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
          in_extop == 3'd3 ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
          in_extop == 3'd4 ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
          32'h0;
    zimm = in_extop == 3'd5 ? {1'b0, in_inst[19:15]} :
           in_extop == 3'd6 ? (XLEN == 64 ? in_inst[25:20] : {1'b0, in_inst[24:20]}) :
           6'h0;
    zext = in_extop == 3'd5 || in_extop == 3'd6;
    sx = XLEN'($signed(i32));
    imm = zext ? XLEN'(zimm) : sx;
  end
`ifdef YSYX_24100027_IMM_TARGET_EN
  assign new_e = {in_pc + imm, imm, in_pc, in_extop == 3'd7};
  assign out_target = main_q[3*XLEN:2*XLEN+1];
`else
  assign new_e = {imm, in_pc, in_extop == 3'd7};
`endif
  assign unused = ^in_inst[6:0];
  assign in_ready = !skid_v && !rst;
  assign in_fire = in_valid && in_ready;
  assign out_fire = main_v && out_ready;
  assign main_free = !main_v || out_fire;
  assign out_valid = main_v;
  assign out_illegal = main_q[0];
  assign out_pc = main_q[XLEN:1];
  assign out_imm = main_q[2*XLEN:XLEN+1];
  // skid drains into main first; new data then lands in whichever slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (out_fire) begin
        main_v <= skid_v;
        if (skid_v) begin
          main_q <= skid_q;
          skid_v <= 1'b0;
        end
      end
      if (in_fire) begin
        if (main_free) begin
          main_q <= new_e;
          main_v <= 1'b1;
        end else begin
          skid_q <= new_e;
          skid_v <= 1'b1;
        end
      end
    end
  end
endmodule
